seq_detect_ctrl: RTL and testbench

Run controller for the serial Mealy pattern detectors. It latches a pattern configuration on start and scans a valid-qualified serial bit stream. It counts pattern matches with or without overlap, and ends the run on reaching a target match count, on timeout, or on abort. It sits between the test-sequencing logic (start/abort, config) and the serial input line.

---
 rtl/seq_detect_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// ---------------------------------------------------------------------------
// seq_detect_ctrl
//
// Run controller for a serial Mealy pattern detector. A run starts with
// start_i: the configuration is clamped and copied into shadow registers,
// and the controller spends one ARM cycle before it moves to RUN. In RUN it
// scans a valid-qualified serial bit stream for the shadow pattern. Matches
// may overlap or not. The run ends on reaching the target match count (DONE),
// on timeout (TMO), or on abort (IDLE).
//
// Ports
//   clk_i           clock, rising edge
//   rst_ni          asynchronous reset, active low
//   start_i         begin a run (sampled in IDLE, DONE, TMO only)
//   abort_i         end any run and return to IDLE; wins over start_i
//   cfg_pattern_i   pattern; bit [len-1] is received first, bit [0] last
//   cfg_len_i       pattern length; 0 -> 1, values above PAT_W -> PAT_W
//   cfg_overlap_i   1 = overlapping matches allowed
//   cfg_target_i    matches needed for DONE; 0 -> 1
//   cfg_timeout_i   maximum number of RUN cycles; 0 disables the timeout
//   in_i            serial data bit
//   in_valid_i      in_i is meaningful this cycle
//   busy_o          state is ARM or RUN
//   match_o         combinational Mealy match pulse
//   match_cnt_o     matches in the current or last run
//   done_o          target reached (held)
//   timeout_flag_o  timeout expired (held)
// ---------------------------------------------------------------------------
module seq_detect_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int TMO_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [PAT_W-1:0] cfg_pattern_i,
  input  logic [4:0]       cfg_len_i,
  input  logic             cfg_overlap_i,
  input  logic [CNT_W-1:0] cfg_target_i,
  input  logic [TMO_W-1:0] cfg_timeout_i,
  input  logic             in_i,
  input  logic             in_valid_i,
  output logic             busy_o,
  output logic             match_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic             done_o,
  output logic             timeout_flag_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3,
    S_TMO  = 3'd4
  } state_e;

  localparam logic [4:0] PAT_W_L = 5'(PAT_W);

  // ---------------------------------------------------------------------
  // State and storage
  // ---------------------------------------------------------------------
  state_e             state_q,   state_d;
  logic [PAT_W-1:0]   pat_q,     pat_d;
  logic [4:0]         len_q,     len_d;
  logic               ovl_q,     ovl_d;
  logic [CNT_W-1:0]   tgt_q,     tgt_d;
  logic [TMO_W-1:0]   tmo_q,     tmo_d;
  // Only PAT_W-1 past bits are needed: the current bit completes the window.
  logic [PAT_W-2:0]   hist_q,    hist_d;
  logic [4:0]         fill_q,    fill_d;
  logic [TMO_W-1:0]   timer_q,   timer_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               done_q,    done_d;
  logic               tflag_q,   tflag_d;

  // ---------------------------------------------------------------------
  // Configuration clamping (applied before the values are shadowed)
  // ---------------------------------------------------------------------
  logic [4:0]       len_clamped;
  logic [CNT_W-1:0] tgt_clamped;

  always_comb begin
    len_clamped = cfg_len_i;
    if (cfg_len_i == 5'd0) begin
      len_clamped = 5'd1;
    end else if (cfg_len_i > PAT_W_L) begin
      len_clamped = PAT_W_L;
    end
  end

  assign tgt_clamped = (cfg_target_i == '0) ? CNT_W'(1) : cfg_target_i;

  // ---------------------------------------------------------------------
  // Pattern comparison
  // ---------------------------------------------------------------------
  logic [PAT_W-1:0] cand;
  logic [PAT_W-1:0] len_mask;
  logic             pat_equal;
  logic [4:0]       fill_inc;
  logic [4:0]       fill_sat;
  logic             run_valid;
  logic             hit;
  logic [CNT_W-1:0] cnt_inc;
  logic             tgt_hit;
  logic             tmo_last;

  assign cand = {hist_q, in_i};

  // Only the low len_q bits of the window take part in the compare.
  for (genvar gi = 0; gi < PAT_W; gi++) begin : g_len_mask
    assign len_mask[gi] = (5'(gi) < len_q);
  end

  assign pat_equal = (((cand ^ pat_q) & len_mask) == '0);

  // fill_q never exceeds PAT_W (<= 16), so the increment fits in 5 bits.
  assign fill_inc  = fill_q + 5'd1;
  assign fill_sat  = (fill_inc > PAT_W_L) ? PAT_W_L : fill_inc;

  assign run_valid = (state_q == S_RUN) && in_valid_i;
  // A match needs enough received bits to cover the whole pattern.
  assign hit       = run_valid && (fill_inc >= len_q) && pat_equal;

  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign tgt_hit   = hit && (cnt_inc == tgt_q);

  // timer_q counts completed RUN cycles, so the cycle in which it reaches
  // tmo_q-1 is the last one allowed.
  assign tmo_last  = (tmo_q != '0) &&
                     (({1'b0, timer_q} + (TMO_W+1)'(1)) == {1'b0, tmo_q});

  // ---------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    tgt_d   = tgt_q;
    tmo_d   = tmo_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    tflag_d = tflag_q;

    if (abort_i) begin
      // Abort beats everything, including a simultaneous start or match;
      // the count of the interrupted run stays visible.
      state_d = S_IDLE;
      done_d  = 1'b0;
      tflag_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_TMO: begin
          if (start_i) begin
            pat_d   = cfg_pattern_i;
            len_d   = len_clamped;
            ovl_d   = cfg_overlap_i;
            tgt_d   = tgt_clamped;
            tmo_d   = cfg_timeout_i;
            hist_d  = '0;
            fill_d  = '0;
            timer_d = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
            tflag_d = 1'b0;
            state_d = S_ARM;
          end
        end

        S_ARM: begin
          state_d = S_RUN;
        end

        S_RUN: begin
          if (tmo_q != '0) begin
            timer_d = timer_q + TMO_W'(1);
          end

          if (in_valid_i) begin
            if (hit && !ovl_q) begin
              hist_d = '0;
              fill_d = '0;
            end else begin
              hist_d = cand[PAT_W-2:0];
              fill_d = fill_sat;
            end
          end

          if (hit) begin
            cnt_d = cnt_inc;
          end

          // A target-reaching match in the final cycle takes priority
          // over the timeout.
          if (tgt_hit) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (tmo_last) begin
            state_d = S_TMO;
            tflag_d = 1'b1;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      tgt_q   <= '0;
      tmo_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      timer_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      tflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      tgt_q   <= tgt_d;
      tmo_q   <= tmo_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      tflag_q <= tflag_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign busy_o         = (state_q == S_ARM) || (state_q == S_RUN);
  assign match_o        = hit;
  assign match_cnt_o    = cnt_q;
  assign done_o         = done_q;
  assign timeout_flag_o = tflag_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_ctrl
//
// Directed bench for seq_detect_ctrl with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; registered outputs are
// read there, the combinational match output 1 time unit later.
// ---------------------------------------------------------------------------
module tb_seq_detect_ctrl;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int TMO_W = 16;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             start_i;
  logic             abort_i;
  logic [PAT_W-1:0] cfg_pattern_i;
  logic [4:0]       cfg_len_i;
  logic             cfg_overlap_i;
  logic [CNT_W-1:0] cfg_target_i;
  logic [TMO_W-1:0] cfg_timeout_i;
  logic             in_i;
  logic             in_valid_i;
  logic             busy_o;
  logic             match_o;
  logic [CNT_W-1:0] match_cnt_o;
  logic             done_o;
  logic             timeout_flag_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  seq_detect_ctrl #(
    .PAT_W(PAT_W),
    .CNT_W(CNT_W),
    .TMO_W(TMO_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .cfg_pattern_i  (cfg_pattern_i),
    .cfg_len_i      (cfg_len_i),
    .cfg_overlap_i  (cfg_overlap_i),
    .cfg_target_i   (cfg_target_i),
    .cfg_timeout_i  (cfg_timeout_i),
    .in_i           (in_i),
    .in_valid_i     (in_valid_i),
    .busy_o         (busy_o),
    .match_o        (match_o),
    .match_cnt_o    (match_cnt_o),
    .done_o         (done_o),
    .timeout_flag_o (timeout_flag_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One cycle of serial input with its expected match value.
  task automatic feed(input logic b, input logic v, input logic exp_m, input string tag);
    in_i       = b;
    in_valid_i = v;
    #1;
    $display("t=%0t %s in=%0b valid=%0b match=%0b cnt=%0d", $time, tag, b, v, match_o, match_cnt_o);
    chk(tag, {31'd0, match_o}, {31'd0, exp_m});
    tick();
  endtask

  task automatic do_start(input logic [PAT_W-1:0] pat, input logic [4:0] len,
                          input logic ovl, input logic [CNT_W-1:0] tgt,
                          input logic [TMO_W-1:0] tmo);
    cfg_pattern_i = pat;
    cfg_len_i     = len;
    cfg_overlap_i = ovl;
    cfg_target_i  = tgt;
    cfg_timeout_i = tmo;
    in_valid_i    = 1'b0;
    start_i       = 1'b1;
    tick();
    start_i       = 1'b0;
    $display("t=%0t start pat=%0h len=%0d ovl=%0b tgt=%0d tmo=%0d", $time, pat, len, ovl, tgt, tmo);
  endtask

  task automatic do_abort();
    in_valid_i = 1'b0;
    abort_i    = 1'b1;
    tick();
    abort_i    = 1'b0;
    $display("t=%0t abort", $time);
  endtask

  initial begin
    rst_ni        = 1'b0;
    start_i       = 1'b0;
    abort_i       = 1'b0;
    cfg_pattern_i = '0;
    cfg_len_i     = '0;
    cfg_overlap_i = 1'b0;
    cfg_target_i  = '0;
    cfg_timeout_i = '0;
    in_i          = 1'b0;
    in_valid_i    = 1'b0;

    // Reset state
    #12;
    chk("rst_busy",  {31'd0, busy_o}, 32'd0);
    chk("rst_match", {31'd0, match_o}, 32'd0);
    chk("rst_cnt",   {24'd0, match_cnt_o}, 32'd0);
    chk("rst_done",  {31'd0, done_o}, 32'd0);
    chk("rst_tmo",   {31'd0, timeout_flag_o}, 32'd0);
    tick();
    rst_ni = 1'b1;

    // Non-overlapping 101
    do_start(8'b101, 5'd3, 1'b0, 8'd4, 16'd0);
    chk("t1_arm_busy", {31'd0, busy_o}, 32'd1);
    feed(1'b1, 1'b1, 1'b0, "t1_arm_ignore");
    feed(1'b1, 1'b1, 1'b0, "t1_b1");
    feed(1'b0, 1'b1, 1'b0, "t1_b2");
    feed(1'b1, 1'b1, 1'b1, "t1_b3");
    feed(1'b0, 1'b1, 1'b0, "t1_b4");
    feed(1'b1, 1'b1, 1'b0, "t1_b5");
    chk("t1_cnt",  {24'd0, match_cnt_o}, 32'd1);
    chk("t1_busy", {31'd0, busy_o}, 32'd1);
    do_abort();

    // Overlapping 101, target 2
    do_start(8'b101, 5'd3, 1'b1, 8'd2, 16'd0);
    chk("t2_cnt_clr", {24'd0, match_cnt_o}, 32'd0);
    tick();
    feed(1'b1, 1'b1, 1'b0, "t2_b1");
    feed(1'b0, 1'b1, 1'b0, "t2_b2");
    feed(1'b1, 1'b1, 1'b1, "t2_b3");
    feed(1'b0, 1'b1, 1'b0, "t2_b4");
    feed(1'b1, 1'b1, 1'b1, "t2_b5");
    chk("t2_cnt",  {24'd0, match_cnt_o}, 32'd2);
    chk("t2_done", {31'd0, done_o}, 32'd1);
    chk("t2_busy", {31'd0, busy_o}, 32'd0);

    // Valid gaps (start taken from DONE)
    do_start(8'b101, 5'd3, 1'b0, 8'd4, 16'd0);
    chk("t3_done_clr", {31'd0, done_o}, 32'd0);
    tick();
    feed(1'b1, 1'b1, 1'b0, "t3_v1");
    feed(1'b1, 1'b0, 1'b0, "t3_gap1a");
    feed(1'b1, 1'b0, 1'b0, "t3_gap1b");
    feed(1'b0, 1'b1, 1'b0, "t3_v2");
    feed(1'b1, 1'b0, 1'b0, "t3_gap2a");
    feed(1'b1, 1'b0, 1'b0, "t3_gap2b");
    feed(1'b1, 1'b1, 1'b1, "t3_v3");
    chk("t3_cnt", {24'd0, match_cnt_o}, 32'd1);
    do_abort();

    // Timeout after 10 RUN cycles of zeros
    do_start(8'b101, 5'd3, 1'b0, 8'd1, 16'd10);
    tick();
    for (int i = 0; i < 9; i++) feed(1'b0, 1'b1, 1'b0, "t4_zero");
    chk("t4_busy_9",  {31'd0, busy_o}, 32'd1);
    chk("t4_tmo_9",   {31'd0, timeout_flag_o}, 32'd0);
    feed(1'b0, 1'b1, 1'b0, "t4_zero10");
    chk("t4_tmo",     {31'd0, timeout_flag_o}, 32'd1);
    chk("t4_busy",    {31'd0, busy_o}, 32'd0);
    chk("t4_cnt",     {24'd0, match_cnt_o}, 32'd0);
    chk("t4_done",    {31'd0, done_o}, 32'd0);

    // Target reached in the last RUN cycle beats the timeout
    do_start(8'b101, 5'd3, 1'b0, 8'd1, 16'd10);
    chk("t4b_tmo_clr", {31'd0, timeout_flag_o}, 32'd0);
    tick();
    for (int i = 0; i < 7; i++) feed(1'b0, 1'b1, 1'b0, "t4b_zero");
    feed(1'b1, 1'b1, 1'b0, "t4b_c8");
    feed(1'b0, 1'b1, 1'b0, "t4b_c9");
    feed(1'b1, 1'b1, 1'b1, "t4b_c10");
    chk("t4b_done", {31'd0, done_o}, 32'd1);
    chk("t4b_tmo",  {31'd0, timeout_flag_o}, 32'd0);
    chk("t4b_busy", {31'd0, busy_o}, 32'd0);
    chk("t4b_cnt",  {24'd0, match_cnt_o}, 32'd1);

    // Start ignored during RUN, abort beats start, restart
    do_start(8'b101, 5'd3, 1'b1, 8'd10, 16'd0);
    tick();
    feed(1'b1, 1'b1, 1'b0, "t5_b1");
    feed(1'b0, 1'b1, 1'b0, "t5_b2");
    feed(1'b1, 1'b1, 1'b1, "t5_b3");
    start_i = 1'b1;
    feed(1'b0, 1'b1, 1'b0, "t5_b4_start");
    start_i = 1'b0;
    feed(1'b1, 1'b1, 1'b1, "t5_b5");
    chk("t5_cnt",  {24'd0, match_cnt_o}, 32'd2);
    chk("t5_busy", {31'd0, busy_o}, 32'd1);
    start_i = 1'b1;
    do_abort();
    start_i = 1'b0;
    chk("t5_ab_busy", {31'd0, busy_o}, 32'd0);
    chk("t5_ab_cnt",  {24'd0, match_cnt_o}, 32'd2);
    chk("t5_ab_done", {31'd0, done_o}, 32'd0);
    chk("t5_ab_tmo",  {31'd0, timeout_flag_o}, 32'd0);
    do_start(8'b101, 5'd3, 1'b0, 8'd10, 16'd0);
    chk("t5_re_busy", {31'd0, busy_o}, 32'd1);
    chk("t5_re_cnt",  {24'd0, match_cnt_o}, 32'd0);
    tick();
    chk("t5_run_busy", {31'd0, busy_o}, 32'd1);

    // Asynchronous reset in the middle of RUN
    feed(1'b1, 1'b1, 1'b0, "t6_b1");
    feed(1'b0, 1'b1, 1'b0, "t6_b2");
    feed(1'b1, 1'b1, 1'b1, "t6_b3");
    chk("t6_pre_cnt", {24'd0, match_cnt_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("t6_rst_cnt",  {24'd0, match_cnt_o}, 32'd0);
    chk("t6_rst_match", {31'd0, match_o}, 32'd0);
    chk("t6_rst_done", {31'd0, done_o}, 32'd0);
    in_valid_i = 1'b0;
    tick();
    rst_ni = 1'b1;

    // len = 0 behaves as 1: every valid 1 matches pattern bit0 = 1
    do_start(8'h01, 5'd0, 1'b0, 8'd20, 16'd0);
    tick();
    feed(1'b1, 1'b1, 1'b1, "t7_b1");
    feed(1'b0, 1'b1, 1'b0, "t7_b2");
    feed(1'b1, 1'b1, 1'b1, "t7_b3");
    feed(1'b1, 1'b1, 1'b1, "t7_b4");
    chk("t7_cnt", {24'd0, match_cnt_o}, 32'd3);
    do_abort();

    // len = 20 behaves as len = 8
    do_start(8'hCA, 5'd20, 1'b0, 8'd5, 16'd0);
    tick();
    feed(1'b1, 1'b1, 1'b0, "t8_b1");
    feed(1'b0, 1'b1, 1'b0, "t8_b2");
    feed(1'b1, 1'b1, 1'b0, "t8_b3");
    feed(1'b0, 1'b1, 1'b0, "t8_b4");
    feed(1'b1, 1'b1, 1'b0, "t8_b5");
    feed(1'b1, 1'b1, 1'b0, "t8_b6");
    feed(1'b0, 1'b1, 1'b0, "t8_b7");
    feed(1'b0, 1'b1, 1'b0, "t8_b8");
    feed(1'b1, 1'b1, 1'b0, "t8_b9");
    feed(1'b0, 1'b1, 1'b0, "t8_b10");
    feed(1'b1, 1'b1, 1'b0, "t8_b11");
    feed(1'b0, 1'b1, 1'b1, "t8_b12");
    chk("t8_cnt", {24'd0, match_cnt_o}, 32'd1);
    do_abort();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
